vend_ctrl_multi: RTL and testbench

Parametrised successor to the single-product vending controller. It supports N_PROD products with per-product price and stock, and a 4-denomination coin acceptor. Change and refund are paid out serially, one coin per cycle. It also has a payment timeout and a clearable sales total. It sits between the coin/keypad front-end and the display/dispense drivers.

---
 rtl/vend_pkg.sv | 41 ++++
 rtl/vend_change_gen.sv | 43 ++++
 rtl/vend_ctrl_multi.sv | 203 ++++++++++++++++++++
 tb/tb_vend_ctrl_multi.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the multi-product vending controller.
// Holds the coin codes, the code-to-units conversion, the greedy
// change-coin picker and the controller state encoding.
package vend_pkg;

    localparam logic [1:0] COIN_1  = 2'd0;
    localparam logic [1:0] COIN_2  = 2'd1;
    localparam logic [1:0] COIN_5  = 2'd2;
    localparam logic [1:0] COIN_10 = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        PAY,
        VEND,
        CHANGE
    } state_t;

    function automatic logic [3:0] coin_value(input logic [1:0] code);
        logic [3:0] v;
        v = 4'd1;
        case (code)
            COIN_1:  v = 4'd1;
            COIN_2:  v = 4'd2;
            COIN_5:  v = 4'd5;
            COIN_10: v = 4'd10;
            default: v = 4'd1;
        endcase
        return v;
    endfunction

    // Largest coin not exceeding amt (amt is assumed non-zero by callers).
    function automatic logic [1:0] greedy_coin(input logic [15:0] amt);
        logic [1:0] c;
        if (amt >= 16'd10)     c = COIN_10;
        else if (amt >= 16'd5) c = COIN_5;
        else if (amt >= 16'd2) c = COIN_2;
        else                   c = COIN_1;
        return c;
    endfunction

endpackage

// File: rtl/vend_change_gen.sv
// Greedy change serialiser: loads an amount, then emits one coin per
// cycle (largest coin <= remainder) until the remainder is zero.
// Ports: clk, rst (async, active-high), load/amount (start a payout),
//        chg_valid/chg_coin (registered coin output), done (remainder 0).
module vend_change_gen
    import vend_pkg::*;
#(
    parameter int BAL_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [BAL_W-1:0] amount,
    output logic             chg_valid,
    output logic [1:0]       chg_coin,
    output logic             done
);

    logic [BAL_W-1:0] rem;
    logic [1:0]       code;

    always_comb code = greedy_coin(16'(rem));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem       <= '0;
            chg_valid <= 1'b0;
            chg_coin  <= COIN_1;
        end else if (load) begin
            rem       <= amount;
            chg_valid <= 1'b0;
        end else if (rem != '0) begin
            chg_valid <= 1'b1;
            chg_coin  <= code;
            rem       <= rem - BAL_W'(coin_value(code));
        end else begin
            chg_valid <= 1'b0;
        end
    end

    assign done = (rem == '0);

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-product vending controller: product select, 4-denomination coin
// acceptance, purchase with serial change payout, cancel/timeout refund,
// per-product stock with restock, and a clearable sales total.
// Ports: clk, rst (async, active-high); coin_valid/coin_type, sel_valid/
//        sel_idx, confirm, cancel, restock_valid/idx/qty, clr_total in;
//        coin_reject, vend_valid/vend_idx, chg_valid/chg_coin, alarm,
//        busy, balance, price_o, total, stock_o out (all registered).
module vend_ctrl_multi
    import vend_pkg::*;
#(
    parameter int                      N_PROD      = 4,
    parameter int                      BAL_W       = 8,
    parameter int                      STOCK_W     = 4,
    parameter int                      INIT_STOCK  = 5,
    parameter logic [N_PROD*BAL_W-1:0] PRICES      = {8'd10, 8'd5, 8'd2, 8'd1},
    parameter int                      TOTAL_W     = 16,
    parameter int                      TIMEOUT_CYC = 1000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      coin_valid,
    input  logic [1:0]                coin_type,
    input  logic                      sel_valid,
    input  logic [3:0]                sel_idx,
    input  logic                      confirm,
    input  logic                      cancel,
    input  logic                      restock_valid,
    input  logic [3:0]                restock_idx,
    input  logic [STOCK_W-1:0]        restock_qty,
    input  logic                      clr_total,
    output logic                      coin_reject,
    output logic                      vend_valid,
    output logic [3:0]                vend_idx,
    output logic                      chg_valid,
    output logic [1:0]                chg_coin,
    output logic                      alarm,
    output logic                      busy,
    output logic [BAL_W-1:0]          balance,
    output logic [BAL_W-1:0]          price_o,
    output logic [TOTAL_W-1:0]        total,
    output logic [N_PROD*STOCK_W-1:0] stock_o
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    state_t             state, state_n;
    logic [3:0]         idx, idx_n;
    logic [TW-1:0]      tmo, tmo_n;
    logic [BAL_W-1:0]   balance_n, price_n, sel_price, gen_amount;
    logic [TOTAL_W-1:0] total_n;
    logic [STOCK_W-1:0] stock   [N_PROD];
    logic [STOCK_W-1:0] stock_n [N_PROD];
    logic [BAL_W:0]     coin_sum;
    logic [3:0]         vend_idx_n;
    logic               coin_reject_n, vend_valid_n, alarm_n, busy_n;
    logic               sel_ok, sale, gen_load, gen_done;

    vend_change_gen #(.BAL_W(BAL_W)) u_chg (
        .clk       (clk),
        .rst       (rst),
        .load      (gen_load),
        .amount    (gen_amount),
        .chg_valid (chg_valid),
        .chg_coin  (chg_coin),
        .done      (gen_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            tmo         <= '0;
            balance     <= '0;
            price_o     <= '0;
            total       <= '0;
            coin_reject <= 1'b0;
            vend_valid  <= 1'b0;
            vend_idx    <= '0;
            alarm       <= 1'b0;
            busy        <= 1'b0;
            for (int unsigned i = 0; i < N_PROD; i++) stock[i] <= STOCK_W'(INIT_STOCK);
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            tmo         <= tmo_n;
            balance     <= balance_n;
            price_o     <= price_n;
            total       <= total_n;
            coin_reject <= coin_reject_n;
            vend_valid  <= vend_valid_n;
            vend_idx    <= vend_idx_n;
            alarm       <= alarm_n;
            busy        <= busy_n;
            for (int unsigned i = 0; i < N_PROD; i++) stock[i] <= stock_n[i];
        end
    end

    // Index compares instead of direct array indexing keep out-of-range
    // selects harmless for any N_PROD.
    always_comb begin
        sel_ok    = 1'b0;
        sel_price = '0;
        for (int unsigned i = 0; i < N_PROD; i++) begin
            if (4'(i) == sel_idx) begin
                sel_ok    = (stock[i] != '0);
                sel_price = PRICES[i*BAL_W +: BAL_W];
            end
        end
    end

    always_comb coin_sum = {1'b0, balance} + (BAL_W+1)'(coin_value(coin_type));

    always_comb begin
        state_n       = state;
        idx_n         = idx;
        tmo_n         = tmo;
        balance_n     = balance;
        price_n       = price_o;
        total_n       = clr_total ? '0 : total;
        coin_reject_n = 1'b0;
        vend_valid_n  = 1'b0;
        vend_idx_n    = vend_idx;
        alarm_n       = 1'b0;
        sale          = 1'b0;
        gen_load      = 1'b0;
        gen_amount    = balance;
        case (state)
            IDLE: begin
                if (sel_valid) begin
                    if (sel_ok) begin
                        idx_n   = sel_idx;
                        price_n = sel_price;
                        tmo_n   = '0;
                        state_n = PAY;
                    end else begin
                        alarm_n = 1'b1;
                    end
                end
                if (coin_valid) coin_reject_n = 1'b1;
            end
            PAY: begin
                tmo_n = tmo + TW'(1);
                if (cancel) begin
                    state_n  = CHANGE;
                    gen_load = 1'b1;
                end else if (coin_valid) begin
                    tmo_n = '0;
                    if (coin_sum[BAL_W]) coin_reject_n = 1'b1;
                    else                 balance_n     = coin_sum[BAL_W-1:0];
                end else if (confirm) begin
                    if (balance >= price_o) state_n = VEND;
                    else                    alarm_n = 1'b1;
                end else if (tmo >= TW'(TIMEOUT_CYC - 1)) begin
                    state_n  = CHANGE;
                    gen_load = 1'b1;
                end
            end
            VEND: begin
                vend_valid_n = 1'b1;
                vend_idx_n   = idx;
                sale         = 1'b1;
                balance_n    = balance - price_o;
                total_n      = total_n + TOTAL_W'(price_o);
                gen_load     = 1'b1;
                gen_amount   = balance - price_o;
                state_n      = CHANGE;
                if (coin_valid) coin_reject_n = 1'b1;
            end
            CHANGE: begin
                // balance mirrors the serialiser's remainder coin by coin
                if (gen_done) begin
                    state_n = IDLE;
                    price_n = '0;
                end else begin
                    balance_n = balance - BAL_W'(coin_value(greedy_coin(16'(balance))));
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    // Vend decrement first, then restock add with saturation.
    always_comb begin
        for (int unsigned i = 0; i < N_PROD; i++) begin
            logic [STOCK_W-1:0] s;
            logic [STOCK_W:0]   sum;
            s   = stock[i];
            sum = '0;
            if (sale && (4'(i) == idx)) s = s - STOCK_W'(1);
            if (restock_valid && (4'(i) == restock_idx)) begin
                sum = {1'b0, s} + {1'b0, restock_qty};
                s   = sum[STOCK_W] ? '1 : sum[STOCK_W-1:0];
            end
            stock_n[i] = s;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N_PROD; i++) stock_o[i*STOCK_W +: STOCK_W] = stock[i];
    end

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Self-checking bench for vend_ctrl_multi: directed stimulus pushes the
// expected output events into a queue; a monitor pops and compares them
// whenever the DUT pulses vend_valid, chg_valid, alarm or coin_reject.
module tb_vend_ctrl_multi;

    localparam int TIMEOUT_CYC = 1000;

    localparam logic [1:0] K_VEND  = 2'd0;
    localparam logic [1:0] K_CHG   = 2'd1;
    localparam logic [1:0] K_ALARM = 2'd2;
    localparam logic [1:0] K_REJ   = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [3:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        coin_valid, sel_valid, confirm, cancel, restock_valid, clr_total;
    logic [1:0]  coin_type;
    logic [3:0]  sel_idx, restock_idx, restock_qty;
    logic        coin_reject, vend_valid, chg_valid, alarm, busy;
    logic [3:0]  vend_idx;
    logic [1:0]  chg_coin;
    logic [7:0]  balance, price_o;
    logic [15:0] total, stock_o;

    ev_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    vend_ctrl_multi #(
        .N_PROD      (4),
        .BAL_W       (8),
        .STOCK_W     (4),
        .INIT_STOCK  (5),
        .PRICES      ({8'd10, 8'd5, 8'd2, 8'd1}),
        .TOTAL_W     (16),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .coin_valid    (coin_valid),
        .coin_type     (coin_type),
        .sel_valid     (sel_valid),
        .sel_idx       (sel_idx),
        .confirm       (confirm),
        .cancel        (cancel),
        .restock_valid (restock_valid),
        .restock_idx   (restock_idx),
        .restock_qty   (restock_qty),
        .clr_total     (clr_total),
        .coin_reject   (coin_reject),
        .vend_valid    (vend_valid),
        .vend_idx      (vend_idx),
        .chg_valid     (chg_valid),
        .chg_coin      (chg_coin),
        .alarm         (alarm),
        .busy          (busy),
        .balance       (balance),
        .price_o       (price_o),
        .total         (total),
        .stock_o       (stock_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void push(input logic [1:0] k, input logic [3:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endfunction

    task automatic check_ev(input logic [1:0] k, input logic [3:0] d);
        ev_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d data %0d, expected none", k, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== k || e.data !== d) begin
                n_fail++;
                $display("FAIL event: got kind %0d data %0d, expected kind %0d data %0d",
                         k, d, e.kind, e.data);
            end
        end
    endtask

    // Monitor: outputs are registered, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (vend_valid === 1'b1)  check_ev(K_VEND, vend_idx);
            if (chg_valid === 1'b1)   check_ev(K_CHG, {2'b00, chg_coin});
            if (alarm === 1'b1)       check_ev(K_ALARM, 4'd0);
            if (coin_reject === 1'b1) check_ev(K_REJ, 4'd0);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_sel(input logic [3:0] i, input bit bad);
        sel_valid = 1'b1;
        sel_idx   = i;
        if (bad) push(K_ALARM, 4'd0);
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic do_coin(input logic [1:0] t, input bit rej);
        coin_valid = 1'b1;
        coin_type  = t;
        if (rej) push(K_REJ, 4'd0);
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic do_confirm(input bit ok, input logic [3:0] vi);
        confirm = 1'b1;
        if (ok) push(K_VEND, vi);
        else    push(K_ALARM, 4'd0);
        tick();
        confirm = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int bound);
        int k = 0;
        while (busy !== 1'b0 && k < bound) begin
            tick();
            k++;
        end
        chk(name, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        coin_valid = 0; coin_type = 0; sel_valid = 0; sel_idx = 0;
        confirm = 0; cancel = 0; restock_valid = 0; restock_idx = 0;
        restock_qty = 0; clr_total = 0;
        tick(2);
        chk("rst_balance", balance, 0);
        chk("rst_price", price_o, 0);
        chk("rst_total", total, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stock", stock_o, 16'h5555);
        rst = 1'b0;
        tick();

        // Buy product 2 (price 5) with a 10 -> one 5-unit coin change
        do_sel(4'd2, 0);
        chk("t1_price", price_o, 5);
        chk("t1_busy", busy, 1);
        do_coin(2'd3, 0);
        chk("t1_balance", balance, 10);
        do_confirm(1, 4'd2);
        push(K_CHG, 4'd2);
        wait_idle("t1_idle", 20);
        chk("t1_stock2", stock_o[11:8], 4);
        chk("t1_total", total, 5);
        chk("t1_bal0", balance, 0);
        chk("t1_price0", price_o, 0);

        // Insufficient funds, then cancel refunds 5 then 2
        do_sel(4'd3, 0);
        do_coin(2'd2, 0);
        do_coin(2'd1, 0);
        chk("t2_balance", balance, 7);
        do_confirm(0, 4'd0);
        chk("t2_still_pay", busy, 1);
        push(K_CHG, 4'd2);
        push(K_CHG, 4'd1);
        do_cancel();
        wait_idle("t2_idle", 20);
        chk("t2_bal0", balance, 0);
        chk("t2_total", total, 5);

        // Drain product 0, sold-out select, restock
        for (int k = 0; k < 5; k++) begin
            do_sel(4'd0, 0);
            do_coin(2'd0, 0);
            do_confirm(1, 4'd0);
            wait_idle("t3_idle", 20);
        end
        chk("t3_stock0", stock_o[3:0], 0);
        chk("t3_total", total, 10);
        do_sel(4'd0, 1);
        chk("t3_soldout_idle", busy, 0);
        restock_valid = 1'b1; restock_idx = 4'd0; restock_qty = 4'd3;
        tick();
        restock_valid = 1'b0;
        chk("t3_restock", stock_o[3:0], 3);

        // Balance overflow boundary, invalid index, coin in IDLE
        do_sel(4'd3, 0);
        for (int k = 0; k < 25; k++) do_coin(2'd3, 0);
        chk("t4_bal250", balance, 250);
        do_coin(2'd3, 1);
        chk("t4_rej10", balance, 250);
        do_coin(2'd2, 0);
        chk("t4_bal255", balance, 255);
        do_coin(2'd0, 1);
        chk("t4_rej1", balance, 255);
        for (int k = 0; k < 25; k++) push(K_CHG, 4'd3);
        push(K_CHG, 4'd2);
        do_cancel();
        wait_idle("t4_idle", 60);
        chk("t4_stock3", stock_o[15:12], 5);
        do_sel(4'd7, 1);
        chk("t4_badidx_idle", busy, 0);
        do_coin(2'd1, 1);

        // Timeout refund
        do_sel(4'd1, 0);
        do_coin(2'd0, 0);
        tick(TIMEOUT_CYC - 20);
        chk("t5_pre_timeout", busy, 1);
        chk("t5_pre_bal", balance, 1);
        push(K_CHG, 4'd0);
        wait_idle("t5_idle", 100);
        chk("t5_bal0", balance, 0);

        // Coin and confirm together, then a sale with clr_total
        do_sel(4'd1, 0);
        do_coin(2'd0, 0);
        coin_valid = 1'b1; coin_type = 2'd0; confirm = 1'b1;
        tick();
        coin_valid = 1'b0; confirm = 1'b0;
        chk("t6_coin_wins", balance, 2);
        chk("t6_no_vend", busy, 1);
        confirm = 1'b1;
        push(K_VEND, 4'd1);
        tick();
        confirm = 1'b0;
        clr_total = 1'b1;
        tick();
        clr_total = 1'b0;
        wait_idle("t6_idle", 20);
        chk("t6_total_clr", total, 2);
        chk("t6_stock1", stock_o[7:4], 4);

        // Restock the vending index in the vend cycle: 4-1+15 saturates
        do_sel(4'd2, 0);
        do_coin(2'd2, 0);
        confirm = 1'b1;
        push(K_VEND, 4'd2);
        tick();
        confirm = 1'b0;
        restock_valid = 1'b1; restock_idx = 4'd2; restock_qty = 4'd15;
        tick();
        restock_valid = 1'b0;
        wait_idle("t7_idle", 20);
        chk("t7_stock2_sat", stock_o[11:8], 15);
        chk("t7_total", total, 7);

        // Reset during CHANGE: second 10 coin is lost
        do_sel(4'd3, 0);
        do_coin(2'd3, 0);
        do_coin(2'd3, 0);
        chk("t8_balance", balance, 20);
        do_cancel();
        chk("t8_in_change", busy, 1);
        push(K_CHG, 4'd3);
        tick();
        #2 rst = 1'b1;
        tick();
        chk("t8_busy", busy, 0);
        chk("t8_balance0", balance, 0);
        chk("t8_chg", chg_valid, 0);
        chk("t8_price", price_o, 0);
        chk("t8_total", total, 0);
        chk("t8_stock", stock_o, 16'h5555);
        rst = 1'b0;
        tick(3);
        chk("t8_after", busy, 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
